// File: rtl/rng_harvester.sv
// Ring-oscillator entropy harvester: gates the oscillators, folds and debiases the
// raw stream, packs words onto a valid/ready port and runs a repetition-count test.
module rng_harvester #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned WARMUP_CYC = 64,
    parameter int unsigned REP_LIMIT  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [SIZE-1:0]  raw_in,
    output logic             ro_en,
    output logic [OUT_W-1:0] rnd_out,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             busy,
    output logic             health_fail
);
    localparam int unsigned BIT_W  = $clog2(OUT_W + 1);
    localparam int unsigned WARM_W = $clog2(WARMUP_CYC + 1);
    localparam int unsigned RUN_W  = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_COLLECT,
        ST_HOLD,
        ST_FAIL
    } state_t;

    state_t             state_q, state_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic               vn_phase_q, vn_phase_d;
    logic               vn_first_q, vn_first_d;
    logic               prev_q, prev_d;
    logic [OUT_W-1:0]   shift_q, shift_d;
    logic [OUT_W-1:0]   rnd_out_q, rnd_out_d;
    logic               b;

    assign b = ^raw_in;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        run_cnt_d  = run_cnt_q;
        vn_phase_d = vn_phase_q;
        vn_first_d = vn_first_q;
        prev_d     = prev_q;
        shift_d    = shift_q;
        rnd_out_d  = rnd_out_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_WARMUP;
                    warm_cnt_d = '0;
                end
            end
            ST_WARMUP: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (warm_cnt_q == WARM_W'(WARMUP_CYC - 1)) begin
                    state_d    = ST_COLLECT;
                    bit_cnt_d  = '0;
                    vn_phase_d = 1'b0;
                    run_cnt_d  = '0;
                    shift_d    = '0;
                end else begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                end
            end
            ST_COLLECT: begin
                // run_cnt of zero marks the first sample of this collection pass
                if (run_cnt_q == '0 || b != prev_q) begin
                    run_cnt_d = RUN_W'(1);
                end else if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
                prev_d = b;

                if (!vn_phase_q) begin
                    vn_first_d = b;
                    vn_phase_d = 1'b1;
                end else begin
                    vn_phase_d = 1'b0;
                    if (b != vn_first_q) begin
                        shift_d   = {shift_q[OUT_W-2:0], vn_first_q};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end

                // Health failure outranks abort and word completion
                if (run_cnt_d == RUN_W'(REP_LIMIT)) begin
                    state_d = ST_FAIL;
                end else if (!req) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_d == BIT_W'(OUT_W)) begin
                    state_d   = ST_HOLD;
                    rnd_out_d = shift_d;
                end
            end
            ST_HOLD: begin
                if (rnd_ready) begin
                    if (req) begin
                        state_d    = ST_WARMUP;
                        warm_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            warm_cnt_q <= '0;
            bit_cnt_q  <= '0;
            run_cnt_q  <= '0;
            vn_phase_q <= 1'b0;
            vn_first_q <= 1'b0;
            prev_q     <= 1'b0;
            shift_q    <= '0;
            rnd_out_q  <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            run_cnt_q  <= run_cnt_d;
            vn_phase_q <= vn_phase_d;
            vn_first_q <= vn_first_d;
            prev_q     <= prev_d;
            shift_q    <= shift_d;
            rnd_out_q  <= rnd_out_d;
        end
    end

    assign ro_en       = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);
    assign rnd_valid   = (state_q == ST_HOLD);
    assign rnd_out     = rnd_out_q;
    assign busy        = (state_q != ST_IDLE);
    assign health_fail = (state_q == ST_FAIL);
endmodule

// File: tb/tb_rng_harvester.sv
// Directed bench for rng_harvester: one instance for the word path, a second with a
// short repetition limit for the health test.
module tb_rng_harvester;
    localparam int unsigned SIZE  = 8;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned WARM  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req, rnd_ready;
    logic [SIZE-1:0]  raw_in;
    logic             ro_en, rnd_valid, busy, health_fail;
    logic [OUT_W-1:0] rnd_out;

    logic             h_req, h_ready;
    logic [SIZE-1:0]  h_raw;
    logic             h_ro_en, h_valid, h_busy, h_fail;
    logic [OUT_W-1:0] h_out;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    rng_harvester #(.SIZE(SIZE), .OUT_W(OUT_W), .WARMUP_CYC(WARM), .REP_LIMIT(32)) u_dut (
        .clk(clk), .rst(rst), .req(req), .raw_in(raw_in), .ro_en(ro_en),
        .rnd_out(rnd_out), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .busy(busy), .health_fail(health_fail)
    );

    rng_harvester #(.SIZE(SIZE), .OUT_W(OUT_W), .WARMUP_CYC(WARM), .REP_LIMIT(6)) u_hlth (
        .clk(clk), .rst(rst), .req(h_req), .raw_in(h_raw), .ro_en(h_ro_en),
        .rnd_out(h_out), .rnd_valid(h_valid), .rnd_ready(h_ready),
        .busy(h_busy), .health_fail(h_fail)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Random raw byte whose XOR fold equals b
    function automatic logic [SIZE-1:0] mk(input logic b);
        logic [SIZE-1:0] r;
        r = SIZE'($urandom);
        if ((^r) != b) r[0] = ~r[0];
        return r;
    endfunction

    task automatic warm_main(input int unsigned ncyc);
        for (int unsigned i = 0; i < ncyc; i++) begin
            @(negedge clk);
            check("warm_ro_en", 32'(ro_en), 32'd1);
            check("warm_valid", 32'(rnd_valid), 32'd0);
        end
    endtask

    // Each word bit becomes a pair (1 -> 10, 0 -> 01); with disc, a 11/00 pair
    // follows each of the first four bits. Valid must rise exactly after the last sample.
    task automatic feed_word(input logic [7:0] w, input logic disc);
        logic s[$];
        s = {};
        for (int i = 7; i >= 0; i--) begin
            s.push_back(w[i]);
            s.push_back(!w[i]);
            if (disc && i >= 4) begin
                s.push_back(i[0]);
                s.push_back(i[0]);
            end
        end
        for (int k = 0; k < s.size(); k++) begin
            raw_in = mk(s[k]);
            @(negedge clk);
            if (k == s.size() - 2) begin
                check("valid_early", 32'(rnd_valid), 32'd0);
                check("collect_ro_en", 32'(ro_en), 32'd1);
            end
        end
        check("word_valid", 32'(rnd_valid), 32'd1);
        check("word_value", 32'(rnd_out), 32'(w));
        check("hold_ro_en", 32'(ro_en), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; rnd_ready = 1'b0; raw_in = '0;
        h_req = 1'b0; h_ready = 1'b0; h_raw = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_ro_en", 32'(ro_en), 32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_out", 32'(rnd_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fail", 32'(health_fail), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Nominal word; raw held at fold 0 so an early sample would corrupt it
        req = 1'b1; raw_in = mk(1'b0);
        warm_main(WARM + 1);
        feed_word(8'hA5, 1'b0);

        // Backpressure
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(rnd_valid), 32'd1);
            check("bp_out", 32'(rnd_out), 32'hA5);
            check("bp_ro_en", 32'(ro_en), 32'd0);
        end
        rnd_ready = 1'b1;
        @(negedge clk);
        rnd_ready = 1'b0;
        check("xfer_valid", 32'(rnd_valid), 32'd0);
        check("xfer_rewarm", 32'(ro_en), 32'd1);
        check("xfer_busy", 32'(busy), 32'd1);

        // Discarded pairs stretch collection by two cycles each
        raw_in = mk(1'b0);
        warm_main(WARM);
        feed_word(8'hA5, 1'b1);
        rnd_ready = 1'b1; req = 1'b0;
        @(negedge clk);
        rnd_ready = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(rnd_valid), 32'd0);
        check("idle_ro_en", 32'(ro_en), 32'd0);

        // Abort after three accepted bits, then a clean word
        req = 1'b1; raw_in = mk(1'b0);
        warm_main(WARM + 1);
        for (int k = 0; k < 6; k++) begin
            raw_in = mk(k[0] ? 1'b0 : 1'b1);
            @(negedge clk);
        end
        req = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ro_en", 32'(ro_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_valid", 32'(rnd_valid), 32'd0);
        end
        req = 1'b1; raw_in = mk(1'b0);
        warm_main(WARM + 1);
        feed_word(8'h3C, 1'b0);
        rnd_ready = 1'b1; req = 1'b0;
        @(negedge clk);
        rnd_ready = 1'b0;

        // Health: six identical samples with REP_LIMIT=6
        h_req = 1'b1; h_raw = mk(1'b0);
        repeat (WARM + 1) @(negedge clk);
        for (int k = 1; k <= 6; k++) begin
            h_raw = mk(1'b1);
            @(negedge clk);
            if (k < 6) begin
                check("h_no_fail", 32'(h_fail), 32'd0);
                check("h_ro_en_on", 32'(h_ro_en), 32'd1);
            end
        end
        check("h_fail", 32'(h_fail), 32'd1);
        check("h_ro_en_off", 32'(h_ro_en), 32'd0);
        check("h_valid", 32'(h_valid), 32'd0);
        h_req = 1'b0;
        repeat (2) @(negedge clk);
        h_req = 1'b1;
        repeat (3) @(negedge clk);
        check("h_sticky", 32'(h_fail), 32'd1);
        check("h_sticky_busy", 32'(h_busy), 32'd1);
        check("h_sticky_ro_en", 32'(h_ro_en), 32'd0);

        // Asynchronous reset with main in COLLECT and the health instance failed
        req = 1'b1; raw_in = mk(1'b0);
        warm_main(WARM + 1);
        for (int k = 0; k < 4; k++) begin
            raw_in = mk((k == 0 || k == 3) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        check("pre_rst_ro_en", 32'(ro_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_ro_en", 32'(ro_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(rnd_valid), 32'd0);
        check("arst_out", 32'(rnd_out), 32'd0);
        check("arst_h_fail", 32'(h_fail), 32'd0);
        check("arst_h_busy", 32'(h_busy), 32'd0);
        req = 1'b0; h_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_h_fail", 32'(h_fail), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
